// File: rtl/ftq_fetch_reader_pkg.sv
// Shared widths, block FSM encodings and the latched FTQ entry type for the
// fetch-target-queue read side.
package ftq_fetch_reader_pkg;

  localparam int ADDR_W  = 32;
  localparam int PTR_W   = 6;
  localparam int FETCH_N = 4;
  localparam int DATA_W  = 32 * FETCH_N;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_OUT  = 2'd3;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic               taken;
    logic [1:0]         slot;
    logic [ADDR_W-1:0]  target;
    logic [PTR_W-1:0]   ptr;
    logic [FETCH_N-1:0] mask;
  } entry_t;

  function automatic logic [ADDR_W-1:0] align_fetch_addr(input logic [ADDR_W-1:0] pc);
    return {pc[ADDR_W-1:4], 4'b0000};
  endfunction

endpackage

// File: rtl/ftq_fetch_reader_if.sv
// Bundles the FTQ head, ICache and predecode-side signals of the fetch reader.
// master = the reader block, slave = its environment (FTQ, ICache, predecode).
interface ftq_fetch_reader_if;
  import ftq_fetch_reader_pkg::*;

  logic               FetchTQStop;
  logic               FetchTQFlash;
  logic               FetchBusy;
  logic               QEmpty;
  logic [ADDR_W-1:0]  QHeadPc;
  logic               QHeadTaken;
  logic [1:0]         QHeadSlot;
  logic [ADDR_W-1:0]  QHeadTarget;
  logic [PTR_W-1:0]   QHeadPtr;
  logic               QRable;
  logic               IcReq;
  logic [ADDR_W-1:0]  IcAddr;
  logic               IcAck;
  logic               IcRespValid;
  logic [DATA_W-1:0]  IcRespData;
  logic               FetchOutAble;
  logic [ADDR_W-1:0]  FetchOutPc;
  logic [DATA_W-1:0]  FetchOutInst;
  logic [FETCH_N-1:0] FetchOutMask;
  logic [PTR_W-1:0]   FetchOutPtr;
  logic               FetchOutTaken;
  logic [ADDR_W-1:0]  FetchOutTarget;

  modport master (
    input  FetchTQStop, FetchTQFlash, QEmpty, QHeadPc, QHeadTaken, QHeadSlot,
           QHeadTarget, QHeadPtr, IcAck, IcRespValid, IcRespData,
    output FetchBusy, QRable, IcReq, IcAddr, FetchOutAble, FetchOutPc,
           FetchOutInst, FetchOutMask, FetchOutPtr, FetchOutTaken, FetchOutTarget
  );

  modport slave (
    output FetchTQStop, FetchTQFlash, QEmpty, QHeadPc, QHeadTaken, QHeadSlot,
           QHeadTarget, QHeadPtr, IcAck, IcRespValid, IcRespData,
    input  FetchBusy, QRable, IcReq, IcAddr, FetchOutAble, FetchOutPc,
           FetchOutInst, FetchOutMask, FetchOutPtr, FetchOutTaken, FetchOutTarget
  );

endinterface

// File: rtl/ftq_mask_gen.sv
// Turns a block's first slot and predicted-taken slot into the mask of
// instructions that belong to the fetch packet.
module ftq_mask_gen
  import ftq_fetch_reader_pkg::*;
(
  input  logic [1:0]         first_slot,
  input  logic               taken,
  input  logic [1:0]         taken_slot,
  output logic [FETCH_N-1:0] mask
);

  logic [1:0] last_slot;

  // Slots from the start PC up to the taken branch (or group end); a taken
  // slot before the start is a malformed entry and keeps only the first slot.
  always_comb begin
    mask      = '0;
    last_slot = taken ? taken_slot : 2'd3;
    if (taken && (taken_slot < first_slot)) begin
      mask[first_slot] = 1'b1;
    end else begin
      for (int i = 0; i < FETCH_N; i++) begin
        mask[i] = (2'(i) >= first_slot) && (2'(i) <= last_slot);
      end
    end
  end

endmodule

// File: rtl/ftq_fetch_reader.sv
// FTQ read side: pops one predicted block, issues one aligned ICache request,
// captures the line and holds a fetch packet for predecode. A redirect can
// leave one response in flight; DropPend remembers to swallow it.
module ftq_fetch_reader
  import ftq_fetch_reader_pkg::*;
(
  input logic                Clk,
  input logic                Rest,
  ftq_fetch_reader_if.master bus
);

  logic [1:0]         state_q, state_d;
  logic               drop_pend_q, drop_pend_d;
  entry_t             entry_q, entry_d;
  logic [DATA_W-1:0]  inst_q, inst_d;
  logic [FETCH_N-1:0] head_mask;
  logic               pop;
  logic               ic_req;
  logic               ic_fire;

  ftq_mask_gen u_mask_gen (
    .first_slot (bus.QHeadPc[3:2]),
    .taken      (bus.QHeadTaken),
    .taken_slot (bus.QHeadSlot),
    .mask       (head_mask)
  );

  // Pop and request handshakes; no new request while a stale response is owed.
  always_comb begin
    pop     = (state_q == ST_IDLE) && !bus.QEmpty && !bus.FetchTQStop &&
              !bus.FetchTQFlash && !Rest;
    ic_req  = (state_q == ST_REQ) && !drop_pend_q && !Rest;
    ic_fire = ic_req && bus.IcAck;
  end

  // Block FSM, entry/data capture and the in-flight-response drop tracking.
  always_comb begin
    state_d     = state_q;
    entry_d     = entry_q;
    inst_d      = inst_q;
    drop_pend_d = drop_pend_q && !bus.IcRespValid;

    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          entry_d.pc     = bus.QHeadPc;
          entry_d.taken  = bus.QHeadTaken;
          entry_d.slot   = bus.QHeadSlot;
          entry_d.target = bus.QHeadTarget;
          entry_d.ptr    = bus.QHeadPtr;
          entry_d.mask   = head_mask;
          state_d        = ST_REQ;
        end
      end
      ST_REQ: begin
        if (ic_fire) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.IcRespValid) begin
          inst_d  = bus.IcRespData;
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        if (!bus.FetchTQStop) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (bus.FetchTQFlash) begin
      state_d = ST_IDLE;
      inst_d  = inst_q;
      if (((state_q == ST_WAIT) && !bus.IcRespValid) || ic_fire) begin
        drop_pend_d = 1'b1;
      end
    end
  end

  // State registers with synchronous reset clearing every visible output.
  always_ff @(posedge Clk) begin
    if (Rest) begin
      state_q     <= ST_IDLE;
      drop_pend_q <= 1'b0;
      entry_q     <= '0;
      inst_q      <= '0;
    end else begin
      state_q     <= state_d;
      drop_pend_q <= drop_pend_d;
      entry_q     <= entry_d;
      inst_q      <= inst_d;
    end
  end

  assign bus.QRable         = pop;
  assign bus.IcReq          = ic_req;
  assign bus.IcAddr         = align_fetch_addr(entry_q.pc);
  assign bus.FetchBusy      = (state_q != ST_IDLE);
  assign bus.FetchOutAble   = (state_q == ST_OUT);
  assign bus.FetchOutPc     = entry_q.pc;
  assign bus.FetchOutInst   = inst_q;
  assign bus.FetchOutMask   = entry_q.mask;
  assign bus.FetchOutPtr    = entry_q.ptr;
  assign bus.FetchOutTaken  = entry_q.taken;
  assign bus.FetchOutTarget = entry_q.target;

endmodule
